cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl_if.sv | 35 +++
 rtl/cache_ctrl.sv | 143 ++++++++++++++
 tb/tb_cache_ctrl.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cache_ctrl_if.sv
// Bus bundle for the cache controller: CPU handshake, tag/data store
// control and the write-through memory port, plus the statistics counters.
// master = the controller, slave = the surrounding CPU, stores and memory.
interface cache_ctrl_if #(
   parameter int CNT_W = 16
);
   logic             cpu_req;
   logic             cpu_we;
   logic [15:0]      cpu_addr;
   logic             cpu_ready;
   logic             cpu_hit;
   logic [9:0]       tag_index;
   logic             tag_wr;
   logic [3:0]       tag_wdata;
   logic [3:0]       tag_rdata;
   logic             data_we;
   logic             mem_req;
   logic             mem_we;
   logic [15:0]      mem_addr;
   logic             mem_ack;
   logic [CNT_W-1:0] hit_cnt;
   logic [CNT_W-1:0] miss_cnt;

   modport master (
      input  cpu_req, cpu_we, cpu_addr, tag_rdata, mem_ack,
      output cpu_ready, cpu_hit, tag_index, tag_wr, tag_wdata, data_we,
             mem_req, mem_we, mem_addr, hit_cnt, miss_cnt
   );

   modport slave (
      output cpu_req, cpu_we, cpu_addr, tag_rdata, mem_ack,
      input  cpu_ready, cpu_hit, tag_index, tag_wr, tag_wdata, data_we,
             mem_req, mem_we, mem_addr, hit_cnt, miss_cnt
   );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped cache controller: read-allocate, write-through,
// no write-allocate. Tag store is external with a one-cycle registered
// read; the controller owns the valid bits and hit/miss statistics.
module cache_ctrl #(
   parameter int CACHESIZE = 1024,
   parameter int CNT_W     = 16
) (
   input  logic          clock,
   input  logic          reset,
   cache_ctrl_if.master  bus
);

   localparam int IW = $clog2(CACHESIZE);

   typedef enum logic [2:0] {IDLE, COMPARE, REFILL, UPDATE, WTHRU} state_t;

   state_t               state, state_nx;
   logic [15:0]          addr_q;
   logic                 we_q;
   logic                 hit_q;
   logic [CACHESIZE-1:0] valid;
   logic [CNT_W-1:0]     hit_cnt, miss_cnt;

   logic [9:0]           idx_q;
   logic [3:0]           tag_q;
   logic                 hit;

   logic                 tag_wr, data_we, cpu_ready, cpu_hit, mem_req, mem_we;
   logic                 cnt_hit, cnt_miss, set_valid;

   assign idx_q = addr_q[11:2];
   assign tag_q = addr_q[15:12];

   // tag_rdata is the registered lookup of the index presented in IDLE,
   // so it is valid exactly in COMPARE.
   assign hit = valid[idx_q[IW-1:0]] && (bus.tag_rdata == tag_q);

   // State register; reset aborts any memory transaction at once.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state and per-state control strobes.
   always_comb begin
      state_nx  = state;
      tag_wr    = 1'b0;
      data_we   = 1'b0;
      cpu_ready = 1'b0;
      cpu_hit   = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      cnt_hit   = 1'b0;
      cnt_miss  = 1'b0;
      set_valid = 1'b0;
      case (state)
         IDLE: begin
            if (bus.cpu_req) state_nx = COMPARE;
         end
         COMPARE: begin
            cnt_hit  = hit;
            cnt_miss = !hit;
            if (we_q) begin
               // write-through: update the data store only if the line is present
               data_we  = hit;
               state_nx = WTHRU;
            end else if (hit) begin
               cpu_ready = 1'b1;
               cpu_hit   = 1'b1;
               state_nx  = IDLE;
            end else begin
               state_nx = REFILL;
            end
         end
         REFILL: begin
            mem_req = 1'b1;
            if (bus.mem_ack) state_nx = UPDATE;
         end
         UPDATE: begin
            tag_wr    = 1'b1;
            data_we   = 1'b1;
            set_valid = 1'b1;
            cpu_ready = 1'b1;
            state_nx  = IDLE;
         end
         WTHRU: begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
            if (bus.mem_ack) begin
               cpu_ready = 1'b1;
               cpu_hit   = hit_q;
               state_nx  = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Latch the access in IDLE; remember the write lookup result for WTHRU.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         addr_q <= '0;
         we_q   <= 1'b0;
         hit_q  <= 1'b0;
      end else begin
         if (state == IDLE && bus.cpu_req) begin
            addr_q <= bus.cpu_addr;
            we_q   <= bus.cpu_we;
         end
         if (state == COMPARE) hit_q <= hit;
      end
   end

   // Valid bits: only a completed refill marks a line present.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)         valid <= '0;
      else if (set_valid) valid[idx_q[IW-1:0]] <= 1'b1;
   end

   // Saturating statistics, updated once per access in COMPARE.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         hit_cnt  <= '0;
         miss_cnt <= '0;
      end else begin
         if (cnt_hit  && hit_cnt  != {CNT_W{1'b1}}) hit_cnt  <= hit_cnt  + 1'b1;
         if (cnt_miss && miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + 1'b1;
      end
   end

   assign bus.tag_index = (state == IDLE) ? bus.cpu_addr[11:2] : idx_q;
   assign bus.tag_wr    = tag_wr;
   assign bus.tag_wdata = tag_wr ? tag_q : 4'h0;
   assign bus.data_we   = data_we;
   assign bus.cpu_ready = cpu_ready;
   assign bus.cpu_hit   = cpu_hit;
   assign bus.mem_req   = mem_req;
   assign bus.mem_we    = mem_we;
   assign bus.mem_addr  = mem_req ? addr_q : 16'h0;
   assign bus.hit_cnt   = hit_cnt;
   assign bus.miss_cnt  = miss_cnt;

endmodule

// File: tb/tb_cache_ctrl.sv
// Bench for cache_ctrl: transaction-level cache model (valid/tag arrays and
// hit/miss totals), a per-cycle compare process, and a second instance with
// 2-bit counters run in lockstep to exercise saturation.
module tb_cache_ctrl;

   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   cache_ctrl_if #(.CNT_W(16)) bus ();
   cache_ctrl_if #(.CNT_W(2))  bus2 ();

   cache_ctrl #(.CACHESIZE(1024), .CNT_W(16)) dut (
      .clock (clock), .reset (reset), .bus (bus));

   cache_ctrl #(.CACHESIZE(1024), .CNT_W(2)) dut_sat (
      .clock (clock), .reset (reset), .bus (bus2));

   // the saturating instance sees identical inputs, so it tracks the same path
   assign bus2.cpu_req   = bus.cpu_req;
   assign bus2.cpu_we    = bus.cpu_we;
   assign bus2.cpu_addr  = bus.cpu_addr;
   assign bus2.tag_rdata = bus.tag_rdata;
   assign bus2.mem_ack   = bus.mem_ack;

   // external tag store with registered read
   logic [3:0] tag_mem [1024];
   always @(posedge clock) begin
      bus.tag_rdata <= tag_mem[bus.tag_index];
      if (bus.tag_wr) tag_mem[bus.tag_index] <= bus.tag_wdata;
   end

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit       mvalid [1024];
   bit [3:0] mtag   [1024];
   int       mhit = 0, mmiss = 0;

   function automatic int sat2(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   // ---------------- memory responder ----------------
   int ack_delay = 0;
   initial begin
      int wcnt;
      wcnt = 0;
      bus.mem_ack = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         if (bus.mem_req) begin
            if (wcnt >= ack_delay) bus.mem_ack = 1'b1;
            else begin
               bus.mem_ack = 1'b0;
               wcnt++;
            end
         end else begin
            bus.mem_ack = 1'b0;
            wcnt = 0;
         end
      end
   end

   // ---------------- per-cycle compare ----------------
   bit          busy = 0;
   bit          cur_we = 0;
   logic [15:0] cur_addr = 16'h0;
   bit          exp_hit = 0;
   int          ready_n, tagwr_n, datawe_n, memreq_n;
   logic [3:0]  last_twdata;
   logic [9:0]  last_tidx;
   logic [15:0] last_maddr;
   logic        last_chit;

   always @(negedge clock) begin
      if (reset) begin
         if (!busy) begin
            chk("idle_ctrl", {bus.tag_wr, bus.data_we, bus.cpu_ready, bus.mem_req}, 4'b0);
            chk("idle_tag_index", bus.tag_index, bus.cpu_addr[11:2]);
         end else begin
            chk("busy_tag_index", bus.tag_index, cur_addr[11:2]);
            if (bus.cpu_ready) begin
               ready_n++;
               last_chit = bus.cpu_hit;
               chk("cpu_hit", bus.cpu_hit, exp_hit);
            end
            if (bus.mem_req) begin
               memreq_n++;
               last_maddr = bus.mem_addr;
               chk("mem_addr", bus.mem_addr, cur_addr);
               chk("mem_we", bus.mem_we, cur_we);
            end
            if (bus.tag_wr) begin
               tagwr_n++;
               last_twdata = bus.tag_wdata;
               last_tidx   = bus.tag_index;
               chk("tag_wdata", bus.tag_wdata, cur_addr[15:12]);
            end
            if (bus.data_we) datawe_n++;
         end
      end
   end

   // ---------------- access driver ----------------
   int last_lat;

   task automatic access(input logic [15:0] addr, input bit we, input int delay);
      int  idx, cyc;
      bit  done, need_mem;
      idx = int'(addr[11:2]);
      exp_hit  = mvalid[idx] && (mtag[idx] == addr[15:12]);
      need_mem = we || !exp_hit;
      cur_we   = we;
      cur_addr = addr;
      ready_n = 0; tagwr_n = 0; datawe_n = 0; memreq_n = 0;
      last_twdata = 4'h0; last_tidx = 10'h0; last_maddr = 16'h0; last_chit = 1'b0;
      ack_delay = delay;
      @(posedge clock);
      #1;
      bus.cpu_req  = 1'b1;
      bus.cpu_we   = we;
      bus.cpu_addr = addr;
      busy = 1;
      cyc = 0;
      done = 0;
      while (!done && cyc < 80) begin
         @(negedge clock);
         cyc++;
         if (bus.cpu_ready) done = 1;
      end
      if (!done) chk("ready_timeout", 32'(cyc), 32'hFFFF_FFFF);
      last_lat = cyc;
      @(posedge clock);
      #1;
      bus.cpu_req = 1'b0;
      busy = 0;
      // model update: lookup statistics, then read-allocate only
      if (exp_hit) mhit++;
      else         mmiss++;
      if (!we && !exp_hit) begin
         mvalid[idx] = 1;
         mtag[idx]   = addr[15:12];
      end
      @(negedge clock);
      chk("hit_cnt",      bus.hit_cnt,   mhit);
      chk("miss_cnt",     bus.miss_cnt,  mmiss);
      chk("hit_cnt_sat",  bus2.hit_cnt,  sat2(mhit));
      chk("miss_cnt_sat", bus2.miss_cnt, sat2(mmiss));
      chk("ready_pulses", ready_n, 1);
      chk("tag_wr_cycles", tagwr_n, (!we && !exp_hit) ? 1 : 0);
      chk("data_we_cycles", datawe_n, ((!we && !exp_hit) || (we && exp_hit)) ? 1 : 0);
      chk("mem_used", memreq_n > 0, need_mem);
      if (done) chk("latency", last_lat, !need_mem ? 2 : (we ? 3 + delay : 4 + delay));
   endtask

   task automatic model_reset();
      for (int i = 0; i < 1024; i++) mvalid[i] = 0;
      mhit = 0;
      mmiss = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int guard;
      bus.cpu_req  = 1'b0;
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 16'h1234;
      model_reset();

      // reset state: everything 0, tag_index tracks the CPU address
      repeat (3) @(negedge clock);
      chk("rst_ctrl", {bus.cpu_ready, bus.cpu_hit, bus.tag_wr, bus.data_we, bus.mem_req, bus.mem_we}, 6'b0);
      chk("rst_mem_addr", bus.mem_addr, 16'h0);
      chk("rst_tag_wdata", bus.tag_wdata, 4'h0);
      chk("rst_hit_cnt", bus.hit_cnt, 0);
      chk("rst_miss_cnt", bus.miss_cnt, 0);
      chk("rst_tag_index", bus.tag_index, 10'h08D);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // cold read miss, ack three cycles after the request rises
      access(16'h1234, 1'b0, 3);
      chk("lit_mem_addr", last_maddr, 16'h1234);
      chk("lit_tag_index", last_tidx, 10'h08D);
      chk("lit_tag_wdata", last_twdata, 4'h1);
      chk("lit_miss_cnt", bus.miss_cnt, 1);
      chk("lit_latency_miss", last_lat, 7);

      // re-read: hit, no memory traffic
      access(16'h1234, 1'b0, 1);
      chk("lit_hit_latency", last_lat, 2);
      chk("lit_hit_cnt", bus.hit_cnt, 1);
      chk("lit_hit_nomem", memreq_n, 0);

      // conflicting tag, ack in the same cycle mem_req rises
      access(16'h5234, 1'b0, 0);
      chk("lit_tag_wdata5", last_twdata, 4'h5);
      access(16'h1234, 1'b0, 2);
      chk("lit_evicted_miss", bus.miss_cnt, 3);
      access(16'h5234, 1'b0, 1);

      // write hit and write miss (no allocate)
      access(16'h5234, 1'b1, 2);
      chk("lit_wr_hit", last_chit, 1'b1);
      chk("lit_wr_data_we", datawe_n, 1);
      access(16'h9000, 1'b1, 0);
      chk("lit_wr_miss_cnt", bus.miss_cnt, 5);
      chk("lit_wr_miss_tagwr", tagwr_n, 0);
      access(16'h9000, 1'b0, 1);
      access(16'h9000, 1'b0, 0);

      // reset in the middle of a refill
      begin
         int idx;
         idx = int'(10'h08D);
         exp_hit = mvalid[idx] && (mtag[idx] == 4'h1);
      end
      cur_we = 0; cur_addr = 16'h1234; ack_delay = 50;
      @(posedge clock);
      #1;
      bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234; busy = 1;
      guard = 0;
      while (!bus.mem_req && guard < 10) begin
         @(negedge clock);
         guard++;
      end
      chk("refill_started", bus.mem_req, 1'b1);
      @(negedge clock);
      #2;
      reset = 1'b0;
      #1;
      chk("arst_mem_req", bus.mem_req, 1'b0);
      chk("arst_hit_cnt", bus.hit_cnt, 0);
      chk("arst_miss_cnt", bus.miss_cnt, 0);
      chk("arst_ready", bus.cpu_ready, 1'b0);
      bus.cpu_req = 1'b0;
      busy = 0;
      model_reset();
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // valid bits cleared: previously cached line misses
      access(16'h5234, 1'b0, 1);
      chk("lit_post_rst_miss", bus.miss_cnt, 1);

      // five hits: wide counter counts, 2-bit counter saturates and holds
      for (int i = 0; i < 5; i++) access(16'h5234, 1'b0, 0);
      chk("lit_hit5", bus.hit_cnt, 5);
      chk("lit_sat_hit", bus2.hit_cnt, 2'd3);
      access(16'h5234, 1'b0, 0);
      chk("lit_sat_hold", bus2.hit_cnt, 2'd3);

      repeat (3) @(negedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
